// File: rtl/mem_load_ctrl_pkg.sv
// mem_load_ctrl_pkg: load-detail bit indices shared with the store side and MEM-stage state encoding
package mem_load_ctrl_pkg;
  localparam int LD_DTL_W = 7;
  localparam int DTL_LW  = 0;
  localparam int DTL_LB  = 1;
  localparam int DTL_LBU = 2;
  localparam int DTL_LH  = 3;
  localparam int DTL_LHU = 4;
  localparam int DTL_LWL = 5;
  localparam int DTL_LWR = 6;
  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_FULL} ms_state_t;
endpackage

// File: rtl/load_data_fmt.sv
// load_data_fmt: byte/half extract and extend plus lwl/lwr merge (merge only with MEM_UNALIGNED_LD_EN)
module load_data_fmt
  import mem_load_ctrl_pkg::*;
(
  input  logic [LD_DTL_W-1:0] dtl,
  input  logic [1:0]          ea,
  input  logic [31:0]         rdata,
`ifdef MEM_UNALIGNED_LD_EN
  input  logic [31:0]         rt,
`endif
  output logic [31:0]         result
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] word;
  assign b = rdata[{ea, 3'b000} +: 8];
  assign h = rdata[{ea[1], 4'b0000} +: 16];
`ifdef MEM_UNALIGNED_LD_EN
  logic [31:0] lwl;
  logic [31:0] lwr;
  assign lwl = ea == 2'd0 ? {rdata[7:0], rt[23:0]} :
               ea == 2'd1 ? {rdata[15:0], rt[15:0]} :
               ea == 2'd2 ? {rdata[23:0], rt[7:0]} : rdata;
  assign lwr = ea == 2'd0 ? rdata :
               ea == 2'd1 ? {rt[31:24], rdata[31:8]} :
               ea == 2'd2 ? {rt[31:16], rdata[31:16]} : {rt[31:8], rdata[31:24]};
  assign word = dtl[DTL_LWL] ? lwl : dtl[DTL_LWR] ? lwr : dtl[DTL_LW] ? rdata : '0;
`else
  assign word = (dtl[DTL_LW] | dtl[DTL_LWL] | dtl[DTL_LWR]) ? rdata : '0;
`endif
  assign result = dtl[DTL_LB]  ? {{24{b[7]}}, b} :
                  dtl[DTL_LBU] ? {24'b0, b} :
                  dtl[DTL_LH]  ? {{16{h[15]}}, h} :
                  dtl[DTL_LHU] ? {16'b0, h} : word;
endmodule

// File: rtl/mem_load_ctrl.sv
// mem_load_ctrl: MEM-stage load-return unit with stale-response discard; MEM_UNALIGNED_LD_EN enables lwl/lwr merge
module mem_load_ctrl
  import mem_load_ctrl_pkg::*;
#(
  parameter int DEST_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic [6:0]        es_ld_dtl,
  input  logic              es_req_issued,
  input  logic [1:0]        es_ea,
  input  logic [31:0]       es_rt_data,
  input  logic [31:0]       es_result,
  input  logic [DEST_W-1:0] es_dest,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              ms_to_ws_valid,
  input  logic              ws_allowin,
  output logic [31:0]       ms_final_result,
  output logic [DEST_W-1:0] ms_dest
);
  ms_state_t           state;
  logic [6:0]          dtl_r;
  logic [1:0]          ea_r;
  logic [CNT_W-1:0]    discard_cnt;
  logic [CNT_W:0]      cnt_sum;
  logic [31:0]         fmt_result;
  logic                es_load_issued;
  logic                accept;
  logic                stale_ok;
  logic                consume;
  assign es_load_issued = (|es_ld_dtl) & es_req_issued;
  assign ms_allowin     = (state == S_EMPTY) | ((state == S_FULL) & ws_allowin);
  assign ms_to_ws_valid = state == S_FULL;
  assign accept         = es_to_ms_valid & ms_allowin & ~flush;
  assign stale_ok       = data_data_ok & (discard_cnt != '0);
  assign consume        = (state == S_WAIT) & data_data_ok & (discard_cnt == '0);
  // A flushed outstanding load and a flushed just-issued load each leave one response to drop
  assign cnt_sum = {1'b0, discard_cnt} - {{CNT_W{1'b0}}, stale_ok}
                 + (flush ? {{CNT_W{1'b0}}, (state == S_WAIT) & ~consume}
                          + {{CNT_W{1'b0}}, es_to_ms_valid & es_load_issued} : '0);
`ifdef MEM_UNALIGNED_LD_EN
  logic [31:0] rt_r;
  load_data_fmt u_fmt (.dtl(dtl_r), .ea(ea_r), .rdata(data_rdata), .rt(rt_r), .result(fmt_result));
`else
  logic unused_rt;
  assign unused_rt = ^es_rt_data;
  load_data_fmt u_fmt (.dtl(dtl_r), .ea(ea_r), .rdata(data_rdata), .result(fmt_result));
`endif
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= S_EMPTY;
      dtl_r           <= '0;
      ea_r            <= '0;
      discard_cnt     <= '0;
      ms_final_result <= '0;
      ms_dest         <= '0;
`ifdef MEM_UNALIGNED_LD_EN
      rt_r            <= '0;
`endif
    end else begin
      assert (!cnt_sum[CNT_W]);
      discard_cnt <= cnt_sum[CNT_W-1:0];
      if (flush) begin
        state <= S_EMPTY;
      end else if (accept) begin
        dtl_r   <= es_ld_dtl;
        ea_r    <= es_ea;
        ms_dest <= es_dest;
`ifdef MEM_UNALIGNED_LD_EN
        rt_r    <= es_rt_data;
`endif
        state   <= es_load_issued ? S_WAIT : S_FULL;
        if (!es_load_issued) ms_final_result <= es_result;
      end else if (consume) begin
        state           <= S_FULL;
        ms_final_result <= fmt_result;
      end else if ((state == S_FULL) & ws_allowin) begin
        state <= S_EMPTY;
      end
    end
  end
endmodule
